// File: rtl/serial_word_adder_if.sv
// ---------------------------------------------------------------------------
// serial_word_adder_if
// Purpose : byte-stream bus between a word producer (master) and the serial
//           word adder (slave).
// Signals : start      - begin a new word addition
//           a_byte     - operand A byte, least significant byte first
//           b_byte     - operand B byte, least significant byte first
//           in_valid   - a_byte/b_byte valid this cycle
//           in_ready   - adder accepts a byte pair this cycle
//           sum_byte   - registered sum byte
//           sum_valid  - one-cycle pulse, sum_byte valid
//           last       - marks the most significant sum byte
//           cout       - final carry-out of the word
//           done       - one-cycle pulse, word complete
//           busy       - adder is processing a word
// ---------------------------------------------------------------------------
interface serial_word_adder_if;
   logic       start;
   logic [7:0] a_byte;
   logic [7:0] b_byte;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] sum_byte;
   logic       sum_valid;
   logic       last;
   logic       cout;
   logic       done;
   logic       busy;

   modport master (
      output start, a_byte, b_byte, in_valid,
      input  in_ready, sum_byte, sum_valid, last, cout, done, busy
   );

   modport slave (
      input  start, a_byte, b_byte, in_valid,
      output in_ready, sum_byte, sum_valid, last, cout, done, busy
   );
endinterface

// File: rtl/serial_word_adder.sv
// ---------------------------------------------------------------------------
// serial_word_adder
// Purpose : adds two NBYTES-wide words one byte pair per cycle, LSB first,
//           on a single 8-bit datapath with a registered inter-byte carry.
// Ports   : i_clk - rising-edge clock
//           i_rst - synchronous, active-high reset
//           bus   - serial_word_adder_if slave modport (handshake, operand
//                   bytes, sum bytes, last/cout/done/busy status)
// ---------------------------------------------------------------------------
module serial_word_adder #(
   parameter int NBYTES = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   serial_word_adder_if.slave bus
);

   localparam int CNT_W = $clog2(NBYTES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_sum_byte;
   logic             r_sum_valid;
   logic             r_last;
   logic             r_cout;
   logic             r_done;
   logic             r_busy;
   logic             r_in_ready;

   state_t           w_state_nx;
   logic             w_carry_nx;
   logic [CNT_W-1:0] w_cnt_nx;
   logic [7:0]       w_sum_byte_nx;
   logic             w_sum_valid_nx;
   logic             w_last_nx;
   logic             w_cout_nx;
   logic             w_done_nx;
   logic [8:0]       w_sum;

   // 8-bit add stage: 9-bit result, bit 8 is the carry into the next byte
   function automatic logic [8:0] add_stage(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic       cin);
      return {1'b0, a} + {1'b0, b} + {8'h00, cin};
   endfunction

   // Next-state and next-output logic for the whole block
   always_comb begin
      w_state_nx     = r_state;
      w_carry_nx     = r_carry;
      w_cnt_nx       = r_cnt;
      w_sum_byte_nx  = r_sum_byte;
      w_sum_valid_nx = 1'b0;
      w_last_nx      = 1'b0;
      w_cout_nx      = r_cout;
      w_done_nx      = 1'b0;
      w_sum          = add_stage(bus.a_byte, bus.b_byte, r_carry);

      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_state_nx = ST_RUN;
               w_carry_nx = 1'b0;
               w_cnt_nx   = '0;
               w_cout_nx  = 1'b0;
            end else begin
               w_state_nx = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bus.in_valid) begin
               w_sum_byte_nx  = w_sum[7:0];
               w_sum_valid_nx = 1'b1;
               w_carry_nx     = w_sum[8];
               if (r_cnt == CNT_LAST) begin
                  // counter parks at zero so it never exceeds NBYTES-1
                  w_last_nx  = 1'b1;
                  w_cout_nx  = w_sum[8];
                  w_cnt_nx   = '0;
                  w_state_nx = ST_FINISH;
               end else begin
                  w_cnt_nx = r_cnt + 1'b1;
               end
            end else begin
               w_state_nx = ST_RUN;
            end
         end
         ST_FINISH: begin
            w_done_nx  = 1'b1;
            w_state_nx = ST_IDLE;
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   // State and output registers; busy/in_ready are derived from the next state
   // so that they are registered yet aligned with the state they describe
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_sum_byte  <= 8'h00;
         r_sum_valid <= 1'b0;
         r_last      <= 1'b0;
         r_cout      <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_in_ready  <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_carry     <= w_carry_nx;
         r_cnt       <= w_cnt_nx;
         r_sum_byte  <= w_sum_byte_nx;
         r_sum_valid <= w_sum_valid_nx;
         r_last      <= w_last_nx;
         r_cout      <= w_cout_nx;
         r_done      <= w_done_nx;
         r_busy      <= (w_state_nx != ST_IDLE);
         r_in_ready  <= (w_state_nx == ST_RUN);
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.sum_byte  = r_sum_byte;
   assign bus.sum_valid = r_sum_valid;
   assign bus.last      = r_last;
   assign bus.cout      = r_cout;
   assign bus.done      = r_done;
   assign bus.busy      = r_busy;

endmodule
